execute_pipelined: RTL and testbench
====================================

Name: execute_pipelined

Overview:
Parametrised successor to the LC3 execute stage. Sits between decode and writeback/memory with valid/ready handshakes on both sides. Adds a WIDTH-generic datapath, an iterative multi-cycle multiply, self-forwarding from its own output register, a load-use stall and a pipeline flush.

Parameters:
WIDTH, 16, datapath width. Immediates and offsets are sign-extended to WIDTH; pc/alu arithmetic wraps modulo 2^WIDTH.
MUL_EN, 1, enables the multiply FSM. When 0, op 4 behaves as ADD.
FWD_EN, 1, enables forwarding of the output register into sr1/sr2 operands.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous pipeline kill
in_valid  in  1  decode offers an instruction
in_ready  out  1  stage accepts this cycle
E_control  in  7  [6:4] alu_op, [3:2] pcselect1, [1] pcselect2, [0] op2select
IR  in  16  instruction word
npc_in  in  WIDTH  next PC
W_control_in  in  2  0=alu result, 1=memory, 2=pcout
reg_we_in  in  1  instruction writes dr
VSR1  in  WIDTH  register-file value of sr1
VSR2  in  WIDTH  register-file value of sr2
sr1  out  3  IR[8:6], combinational
sr2  out  3  IR[2:0], combinational
out_valid  out  1  result register holds a valid instruction
out_ready  in  1  downstream consumes
aluout  out  WIDTH  registered ALU result
pcout  out  WIDTH  registered address/target
dr  out  3  registered IR[11:9]
W_control_out  out  2  registered W_control_in
reg_we_out  out  1  registered reg_we_in

Behaviour:
- Reset (rst=0, async): out_valid=0, aluout=0, pcout=0, dr=0, W_control_out=0, reg_we_out=0, FSM=IDLE, mul counter=0.
- ALU ops:
  - 0 ADD
  - 1 AND
  - 2 NOT op1
  - 3 PASS op2
  - 4 MUL (low WIDTH bits of op1*op2)
  - 5-7 produce 0
- op1 = fwd(VSR1, sr1). op2 = op2select ? fwd(VSR2, sr2) : sext(IR[4:0]).
- Address offsets by pcselect1: 0=sext IR[10:0], 1=sext IR[8:0], 2=sext IR[5:0], 3=sext IR[4:0].
- pcout = offset + (pcselect2 ? npc_in : op1).
- Forwarding (FWD_EN=1) to an operand when out_valid && reg_we_out && dr==src:
  - W_control_out=0: forward aluout.
  - W_control_out=2: forward pcout.
  - W_control_out=1 (load): load-use hazard; in_ready=0 until the output register drains.
- hazard = load-use match on sr1, or on sr2 when op2select=1.
- in_ready = (state==IDLE) && !hazard && !flush && (!out_valid || out_ready).
- Accept condition = in_valid && in_ready.
- Non-MUL accept: all output registers load on the same edge and out_valid=1. Latency 1 cycle.
- MUL accept (MUL_EN=1):
  - Latch op1, op2 and the control/dr/pcout fields; go to MUL and clear acc.
  - Each MUL cycle: if op2 LSB, acc += op1; op1 <<= 1; op2 >>= 1; count++.
  - After WIDTH cycles, aluout=acc, out_valid=1, return to IDLE. Result is registered WIDTH cycles after the accept edge.
- While in MUL, out_valid is cleared once downstream consumes the previous result. The MUL result is written only when !out_valid || out_ready; otherwise the FSM waits in MUL with count saturated.
- out_valid clears on out_ready when no new result loads the same edge. Simultaneous consume and accept: new result loads and out_valid stays 1.
- While out_valid && !out_ready, all outputs hold stable.
- flush=1 at an edge: out_valid=0, FSM=IDLE, partial multiply discarded, no accept. Data registers may keep stale values.
- Reset mid-multiply aborts immediately; the first post-reset accept is a fresh instruction.

Test Plan:
- WIDTH=16, ADD, op2select=1, VSR1=0x7FFF, VSR2=0x0001 -> next cycle out_valid=1, aluout=0x8000. Same with VSR2=0x8001 -> aluout=0x0000 (wrap).
- pcselect1=1, pcselect2=1, IR[8:0]=0x1FE, npc_in=0x3001 -> pcout=0x2FFF. pcselect1=3, pcselect2=0, IR[4:0]=0x05, VSR1=0x0010 -> pcout=0x0015.
- Back-to-back: ADD dr=R2 (result 0x0005), then AND sr1=R2 with imm 0x03 and stale VSR1=0xFFFF -> aluout=0x0001 via forwarding, no bubble. With FWD_EN=0 -> 0x0003.
- Load dr=R3 (W_control=1) held with out_ready=0, next instruction sr1=R3 -> in_ready=0 until out_ready pulses; accept on the following cycle.
- MUL VSR1=0x0007, VSR2=0x0009 -> in_ready=0 for 16 cycles, aluout=0x003F with out_valid. 0xFFFF*0xFFFF -> 0x0001. flush at cycle 5 -> out_valid stays 0 and in_ready returns next cycle.
- Assert rst=0 asynchronously mid-MUL and with out_valid=1 -> all outputs 0 immediately, no clock edge needed.

Source files
------------

// File: rtl/execute_pipelined.sv
// Execute stage: WIDTH-generic ALU/address datapath with valid/ready
// handshakes, self-forwarding from the output register, load-use stall,
// pipeline flush and an iterative shift-add multiplier.
module execute_pipelined #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1,
  parameter bit FWD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       E_control,
  input  logic [15:0]      IR,
  input  logic [WIDTH-1:0] npc_in,
  input  logic [1:0]       W_control_in,
  input  logic             reg_we_in,
  input  logic [WIDTH-1:0] VSR1,
  input  logic [WIDTH-1:0] VSR2,
  output logic [2:0]       sr1,
  output logic [2:0]       sr2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluout,
  output logic [WIDTH-1:0] pcout,
  output logic [2:0]       dr,
  output logic [1:0]       W_control_out,
  output logic             reg_we_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH);

  typedef enum logic [0:0] {S_IDLE, S_MUL} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] pend_pc;
  logic [2:0]       pend_dr;
  logic [1:0]       pend_wc;
  logic             pend_we;

  logic [2:0]       alu_op;
  logic [1:0]       pcselect1;
  logic             pcselect2;
  logic             op2select;
  logic [WIDTH-1:0] imm5;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] src2;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] pc_res;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] acc_fin;
  logic             fwd_hit1;
  logic             fwd_hit2;
  logic             hazard;
  logic             accept;
  logic             is_mul;
  logic             can_write;
  logic             mul_done;
  logic             unused_ir;

  assign alu_op    = E_control[6:4];
  assign pcselect1 = E_control[3:2];
  assign pcselect2 = E_control[1];
  assign op2select = E_control[0];
  assign sr1       = IR[8:6];
  assign sr2       = IR[2:0];
  assign unused_ir = ^IR[15:12];
  assign imm5      = {{(WIDTH-5){IR[4]}}, IR[4:0]};

  // Output-register match against each source register
  assign fwd_hit1 = FWD_EN && out_valid && reg_we_out && (dr == sr1);
  assign fwd_hit2 = FWD_EN && out_valid && reg_we_out && (dr == sr2);

  // A pending load cannot be forwarded; stall until it leaves
  assign hazard = (fwd_hit1 && (W_control_out == 2'd1)) ||
                  (op2select && fwd_hit2 && (W_control_out == 2'd1));

  assign in_ready  = (state == S_IDLE) && !hazard && !flush && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = MUL_EN && (alu_op == 3'd4);
  assign can_write = !out_valid || out_ready;

  // Operand selection with forwarding of ALU or PC results
  always_comb begin
    op1 = VSR1;
    if (fwd_hit1 && (W_control_out == 2'd0))      op1 = aluout;
    else if (fwd_hit1 && (W_control_out == 2'd2)) op1 = pcout;
    src2 = VSR2;
    if (fwd_hit2 && (W_control_out == 2'd0))      src2 = aluout;
    else if (fwd_hit2 && (W_control_out == 2'd2)) src2 = pcout;
    op2 = op2select ? src2 : imm5;
  end

  // Address offset selection and target computation
  always_comb begin
    case (pcselect1)
      2'd0:    offset = {{(WIDTH-11){IR[10]}}, IR[10:0]};
      2'd1:    offset = {{(WIDTH-9){IR[8]}}, IR[8:0]};
      2'd2:    offset = {{(WIDTH-6){IR[5]}}, IR[5:0]};
      default: offset = imm5;
    endcase
    pc_res = offset + (pcselect2 ? npc_in : op1);
  end

  // Single-cycle ALU; op 4 falls back to ADD when the multiplier is absent
  always_comb begin
    case (alu_op)
      3'd0:    alu_res = op1 + op2;
      3'd1:    alu_res = op1 & op2;
      3'd2:    alu_res = ~op1;
      3'd3:    alu_res = op2;
      3'd4:    alu_res = MUL_EN ? '0 : (op1 + op2);
      default: alu_res = '0;
    endcase
  end

  // Final shift-add step is folded into the write so the result lands
  // WIDTH edges after accept; a saturated count means acc is already final.
  assign acc_step = mul_b[0] ? (acc + mul_a) : acc;
  assign mul_done = (cnt >= CNT_LAST);
  assign acc_fin  = (cnt == CNT_SAT) ? acc : acc_step;

  // Control FSM, multiplier datapath and output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      mul_a         <= '0;
      mul_b         <= '0;
      acc           <= '0;
      pend_pc       <= '0;
      pend_dr       <= '0;
      pend_wc       <= '0;
      pend_we       <= 1'b0;
      out_valid     <= 1'b0;
      aluout        <= '0;
      pcout         <= '0;
      dr            <= '0;
      W_control_out <= '0;
      reg_we_out    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      state     <= S_IDLE;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mul_a     <= op1;
              mul_b     <= op2;
              acc       <= '0;
              cnt       <= '0;
              pend_pc   <= pc_res;
              pend_dr   <= IR[11:9];
              pend_wc   <= W_control_in;
              pend_we   <= reg_we_in;
              out_valid <= 1'b0;
              state     <= S_MUL;
            end else begin
              aluout        <= alu_res;
              pcout         <= pc_res;
              dr            <= IR[11:9];
              W_control_out <= W_control_in;
              reg_we_out    <= reg_we_in;
              out_valid     <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        S_MUL: begin
          if (cnt != CNT_SAT) begin
            acc   <= acc_step;
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
          end
          if (mul_done && can_write) begin
            aluout        <= acc_fin;
            pcout         <= pend_pc;
            dr            <= pend_dr;
            W_control_out <= pend_wc;
            reg_we_out    <= pend_we;
            out_valid     <= 1'b1;
            cnt           <= '0;
            state         <= S_IDLE;
          end else begin
            if (cnt != CNT_SAT) cnt <= cnt + CW'(1);
            if (out_ready) out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_pipelined.sv
// Bench for execute_pipelined: vector table, directed multi-cycle
// sequences, then randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_execute_pipelined;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready, reg_we_in;
  logic [6:0]    E_control;
  logic [15:0]   IR, npc_in, VSR1, VSR2;
  logic [1:0]    W_control_in;
  logic          in_ready, out_valid, reg_we_out;
  logic [2:0]    sr1, sr2, dr;
  logic [1:0]    W_control_out;
  logic [15:0]   aluout, pcout;
  logic          in_ready_nf, out_valid_nf, reg_we_out_nf;
  logic [2:0]    sr1_nf, sr2_nf, dr_nf;
  logic [1:0]    W_control_out_nf;
  logic [15:0]   aluout_nf, pcout_nf;

  int checks = 0;
  int errors = 0;

  execute_pipelined #(.WIDTH(W), .MUL_EN(1'b1), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .E_control(E_control), .IR(IR), .npc_in(npc_in), .W_control_in(W_control_in),
    .reg_we_in(reg_we_in), .VSR1(VSR1), .VSR2(VSR2), .sr1(sr1), .sr2(sr2),
    .out_valid(out_valid), .out_ready(out_ready), .aluout(aluout), .pcout(pcout),
    .dr(dr), .W_control_out(W_control_out), .reg_we_out(reg_we_out));

  execute_pipelined #(.WIDTH(W), .MUL_EN(1'b1), .FWD_EN(1'b0)) dut_nf (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_nf),
    .E_control(E_control), .IR(IR), .npc_in(npc_in), .W_control_in(W_control_in),
    .reg_we_in(reg_we_in), .VSR1(VSR1), .VSR2(VSR2), .sr1(sr1_nf), .sr2(sr2_nf),
    .out_valid(out_valid_nf), .out_ready(out_ready), .aluout(aluout_nf), .pcout(pcout_nf),
    .dr(dr_nf), .W_control_out(W_control_out_nf), .reg_we_out(reg_we_out_nf));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  ps1;
    logic        ps2;
    logic        o2s;
    logic [15:0] ir, npc, v1, v2, ealu, epc;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] ps1, input logic ps2,
                       input logic o2s, input logic [15:0] ir, input logic [15:0] npc,
                       input logic [15:0] v1, input logic [15:0] v2,
                       input logic [1:0] wc, input logic we);
    E_control    = {op, ps1, ps2, o2s};
    IR           = ir;
    npc_in       = npc;
    VSR1         = v1;
    VSR2         = v2;
    W_control_in = wc;
    reg_we_in    = we;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_aluout"}, 32'(aluout), 32'(0));
    chk({tag, "_pcout"}, 32'(pcout), 32'(0));
    chk({tag, "_dr"}, 32'(dr), 32'(0));
    chk({tag, "_wc"}, 32'(W_control_out), 32'(0));
    chk({tag, "_we"}, 32'(reg_we_out), 32'(0));
  endtask

  task automatic do_mul(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, input string nm);
    int n;
    int busy;
    drive(3'd4, 2'd0, 1'b0, 1'b1, 16'h0000, 16'h0000, a, b, 2'd0, 1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({nm, "_ready_at_accept"}, 32'(in_ready), 32'(1));
    step();
    in_valid = 1'b0;
    n = 0;
    busy = 0;
    while (!out_valid && n < 40) begin
      if (!in_ready) busy++;
      step();
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(16));
    chk({nm, "_busy_cycles"}, 32'(busy), 32'(16));
    chk({nm, "_aluout"}, 32'(aluout), 32'(exp));
  endtask

  // Reference model state (transaction level)
  logic        mv;
  logic [15:0] m_alu, m_pc, p_alu, p_pc;
  logic [2:0]  m_dr, p_dr;
  logic [1:0]  m_wc, p_wc;
  logic        m_we, p_we;
  int          mbusy;

  function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
    logic signed [31:0] t;
    t = $signed({16'b0, v}) <<< (32 - bits);
    return 16'(t >>> (32 - bits));
  endfunction

  function automatic logic [15:0] mfwd(input logic [2:0] src, input logic [15:0] v);
    if (mv && m_we && m_dr == src) begin
      if (m_wc == 2'd0) return m_alu;
      if (m_wc == 2'd2) return m_pc;
    end
    return v;
  endfunction

  initial begin
    int ov_seen;
    logic [2:0]  op;
    logic [1:0]  ps1;
    logic        ps2, o2s, haz, er;
    logic [15:0] o1, o2, off, pc, res;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(3'd0, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
    #1 rst = 1'b0;
    #1;
    check_zero("reset");
    chk("reset_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    rst = 1'b1;
    step();

    //          op    ps1   ps2  o2s  ir        npc       v1        v2        alu       pc
    vt[0] = '{3'd0, 2'd0, 1'b1, 1'b1, 16'h0000, 16'h1000, 16'h7FFF, 16'h0001, 16'h8000, 16'h1000};
    vt[1] = '{3'd0, 2'd0, 1'b1, 1'b1, 16'h0000, 16'h1000, 16'h7FFF, 16'h8001, 16'h0000, 16'h1000};
    vt[2] = '{3'd3, 2'd1, 1'b1, 1'b0, 16'h01FE, 16'h3001, 16'h0000, 16'h0000, 16'hFFFE, 16'h2FFF};
    vt[3] = '{3'd0, 2'd3, 1'b0, 1'b0, 16'h0005, 16'h0000, 16'h0010, 16'h0000, 16'h0015, 16'h0015};
    vt[4] = '{3'd1, 2'd2, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'hF0F0, 16'h3C3C, 16'h3030, 16'hF0F0};
    vt[5] = '{3'd2, 2'd0, 1'b1, 1'b1, 16'h0400, 16'h0500, 16'h1234, 16'h0000, 16'hEDCB, 16'h0100};
    vt[6] = '{3'd5, 2'd2, 1'b0, 1'b1, 16'h0020, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFDF};
    vt[7] = '{3'd6, 2'd2, 1'b0, 1'b1, 16'h0020, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFDF};
    vt[8] = '{3'd7, 2'd2, 1'b0, 1'b1, 16'h0020, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFDF};
    vt[9] = '{3'd0, 2'd3, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0005, 16'h0000, 16'hFFF5, 16'hFFF5};

    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].op, vt[i].ps1, vt[i].ps2, vt[i].o2s, vt[i].ir, vt[i].npc,
            vt[i].v1, vt[i].v2, 2'd0, 1'b0);
      in_valid = 1'b1;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(1));
      step();
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(1));
      chk($sformatf("vec%0d_aluout", i), 32'(aluout), 32'(vt[i].ealu));
      chk($sformatf("vec%0d_pcout", i), 32'(pcout), 32'(vt[i].epc));
    end
    in_valid = 1'b0;
    step();

    // Forwarding: ADD R2 <- 5, then AND R2 with imm 3 using stale VSR1
    drive(3'd0, 2'd0, 1'b0, 1'b0, 16'h0405, 16'h0, 16'h0000, 16'h0, 2'd0, 1'b1);
    in_valid = 1'b1;
    step();
    chk("fwd_first_alu", 32'(aluout), 32'(16'h0005));
    drive(3'd1, 2'd0, 1'b0, 1'b0, 16'h0083, 16'h0, 16'hFFFF, 16'h0, 2'd0, 1'b0);
    #1;
    chk("fwd_no_bubble", 32'(in_ready), 32'(1));
    step();
    chk("fwd_aluout", 32'(aluout), 32'(16'h0001));
    chk("nofwd_aluout", 32'(aluout_nf), 32'(16'h0003));
    in_valid = 1'b0;
    step();

    // Load-use stall: load R3 held, then consumer of R3
    drive(3'd0, 2'd0, 1'b0, 1'b0, 16'h0600, 16'h0, 16'h0077, 16'h0, 2'd1, 1'b1);
    in_valid = 1'b1;
    step();
    out_ready = 1'b0;
    drive(3'd0, 2'd0, 1'b0, 1'b0, 16'h00C0, 16'h0, 16'h0042, 16'h0, 2'd0, 1'b0);
    #1;
    chk("lu_stall0", 32'(in_ready), 32'(0));
    chk("lu_held_valid", 32'(out_valid), 32'(1));
    step();
    chk("lu_stall1", 32'(in_ready), 32'(0));
    chk("lu_held_alu", 32'(aluout), 32'(16'h0077));
    out_ready = 1'b1;
    #1;
    chk("lu_stall_on_pulse", 32'(in_ready), 32'(0));
    step();
    chk("lu_drained", 32'(out_valid), 32'(0));
    chk("lu_ready_after", 32'(in_ready), 32'(1));
    step();
    chk("lu_accept_valid", 32'(out_valid), 32'(1));
    chk("lu_accept_alu", 32'(aluout), 32'(16'h0042));
    in_valid = 1'b0;
    step();

    do_mul(16'h0007, 16'h0009, 16'h003F, "mul7x9");
    step();
    do_mul(16'hFFFF, 16'hFFFF, 16'h0001, "mulFFFF");
    step();

    // Flush on the fifth edge after a multiply is accepted
    drive(3'd4, 2'd0, 1'b0, 1'b1, 16'h0000, 16'h0, 16'h0003, 16'h0005, 2'd0, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    flush = 1'b1;
    #1;
    chk("flush_blocks_ready", 32'(in_ready), 32'(0));
    step();
    flush = 1'b0;
    #1;
    chk("flush_valid", 32'(out_valid), 32'(0));
    chk("flush_ready_back", 32'(in_ready), 32'(1));
    ov_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid) ov_seen++;
    end
    chk("flush_no_result", 32'(ov_seen), 32'(0));

    // Asynchronous reset in the middle of a multiply
    do_mul(16'h0002, 16'h0003, 16'h0006, "mul2x3");
    drive(3'd4, 2'd0, 1'b0, 1'b1, 16'h0000, 16'h0, 16'h0007, 16'h0009, 2'd0, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    #2 rst = 1'b0;
    #1;
    check_zero("rst_mul");
    chk("rst_mul_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    rst = 1'b1;
    drive(3'd0, 2'd0, 1'b0, 1'b1, 16'h0000, 16'h0, 16'h0002, 16'h0003, 2'd0, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_alu", 32'(aluout), 32'(16'h0005));
    chk("post_rst_valid", 32'(out_valid), 32'(1));
    ov_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid) ov_seen++;
    end
    chk("post_rst_no_stale_mul", 32'(ov_seen), 32'(0));

    // Asynchronous reset while a result is held
    drive(3'd0, 2'd0, 1'b1, 1'b1, 16'h0A00, 16'h1234, 16'h1111, 16'h2222, 2'd2, 1'b1);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("held_alu", 32'(aluout), 32'(16'h3333));
    chk("held_pc", 32'(pcout), 32'(16'h1434));
    #2 rst = 1'b0;
    #1;
    check_zero("rst_held");
    @(negedge clk);
    rst = 1'b1;
    step();

    // Randomized traffic against the model
    mv = 1'b0; mbusy = 0;
    m_alu = '0; m_pc = '0; m_dr = '0; m_wc = '0; m_we = 1'b0;
    p_alu = '0; p_pc = '0; p_dr = '0; p_wc = '0; p_we = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      op  = 3'($urandom_range(0, 7));
      ps1 = 2'($urandom_range(0, 3));
      ps2 = 1'($urandom_range(0, 1));
      o2s = 1'($urandom_range(0, 1));
      drive(op, ps1, ps2, o2s, 16'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      #1;
      haz = mv && m_we && (m_wc == 2'd1) && (m_dr == IR[8:6] || (o2s && m_dr == IR[2:0]));
      er  = (mbusy == 0) && !haz && !flush && (!mv || out_ready);
      chk("rnd_in_ready", 32'(in_ready), 32'(er));
      chk("rnd_out_valid", 32'(out_valid), 32'(mv));
      chk("rnd_sr1", 32'(sr1), 32'(IR[8:6]));
      if (mv) begin
        chk("rnd_aluout", 32'(aluout), 32'(m_alu));
        chk("rnd_pcout", 32'(pcout), 32'(m_pc));
        chk("rnd_dr", 32'(dr), 32'(m_dr));
        chk("rnd_wc", 32'(W_control_out), 32'(m_wc));
        chk("rnd_we", 32'(reg_we_out), 32'(m_we));
      end
      if (flush) begin
        mv = 1'b0;
        mbusy = 0;
      end else if (mbusy > 1) begin
        mbusy--;
        if (out_ready) mv = 1'b0;
      end else if (mbusy == 1) begin
        if (!mv || out_ready) begin
          m_alu = p_alu; m_pc = p_pc; m_dr = p_dr; m_wc = p_wc; m_we = p_we;
          mv = 1'b1;
          mbusy = 0;
        end
      end else if (in_valid && er) begin
        o1 = mfwd(IR[8:6], VSR1);
        o2 = o2s ? mfwd(IR[2:0], VSR2) : sx(IR, 5);
        case (ps1)
          2'd0:    off = sx(IR, 11);
          2'd1:    off = sx(IR, 9);
          2'd2:    off = sx(IR, 6);
          default: off = sx(IR, 5);
        endcase
        pc = off + (ps2 ? npc_in : o1);
        case (op)
          3'd0:    res = o1 + o2;
          3'd1:    res = o1 & o2;
          3'd2:    res = ~o1;
          3'd3:    res = o2;
          3'd4:    res = 16'(32'(o1) * 32'(o2));
          default: res = 16'h0000;
        endcase
        if (op == 3'd4) begin
          p_alu = res; p_pc = pc; p_dr = IR[11:9]; p_wc = W_control_in; p_we = reg_we_in;
          mbusy = 16;
          mv = 1'b0;
        end else begin
          m_alu = res; m_pc = pc; m_dr = IR[11:9]; m_wc = W_control_in; m_we = reg_we_in;
          mv = 1'b1;
        end
      end else if (out_ready) begin
        mv = 1'b0;
      end
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
